// File: rtl/icache.sv
// icache: direct-mapped one-word-per-frame instruction cache with a zero-latency hit path
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;
  typedef enum logic {IDLE, MISS} state_t;
  state_t state;
  logic [SETS-1:0] valid;
  logic [TW-1:0] tags [SETS];
  logic [31:0] data [SETS];
  logic [31:0] maddr;
  logic [IW-1:0] idx, midx;
  logic [TW-1:0] tag;
  assign idx = imemaddr[IW+1:2];
  assign tag = imemaddr[31:IW+2];
  assign midx = maddr[IW+1:2];
  always_comb begin
    ihit = state == IDLE && imemREN && valid[idx] && tags[idx] == tag;
    imemload = ihit ? data[idx] : '0;
    iREN = state == MISS;
    iaddr = state == MISS ? maddr : imemaddr;
  end
  always_ff @(posedge CLK) begin
    if (nRST) begin
      state <= IDLE;
      valid <= '0;
      maddr <= '0;
    end else if (state == IDLE) begin
      if (imemREN && !ihit) begin
        state <= MISS;
        maddr <= imemaddr;
      end
    end else if (!iwait) begin
      valid[midx] <= 1'b1;
      tags[midx] <= maddr[31:IW+2];
      data[midx] <= iload;
      state <= IDLE;
    end
  end
endmodule
